// File: rtl/selector_tablero_pkg.sv
// selector_pkg: cell encodings, button indices, FSM states and clog2 for the board selector
package selector_pkg;
  localparam logic [1:0] CASILLA_VACIA   = 2'b00;
  localparam logic [1:0] CASILLA_EQUIS   = 2'b01;
  localparam logic [1:0] CASILLA_CIRCULO = 2'b10;
  localparam int B_ARRIBA = 0;
  localparam int B_ABAJO  = 1;
  localparam int B_IZQ    = 2;
  localparam int B_DER    = 3;
  localparam int B_ELIGE  = 4;
  typedef enum logic {
    ESPERA = 1'b0,
    LLENO  = 1'b1
  } estado_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/selector_tablero_detector_flanco.sv
// detector_flanco: rising-edge detect on W levels; history starts high so held buttons stay silent
module detector_flanco #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] nivel_i,
  output logic [W-1:0] flanco_o
);
  logic [W-1:0] prev_q;
  always_ff @(posedge clk) prev_q <= reset ? '1 : nivel_i;
  assign flanco_o = nivel_i & ~prev_q;
endmodule

// File: rtl/selector_tablero.sv
// selector_tablero: N x N cursor selector committing player marks, with wrap/saturate, clear and full state
module selector_tablero
  import selector_pkg::*;
#(
  parameter int N    = 3,
  parameter int WRAP = 1,
  parameter int CW   = clog2(N*N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boton_arriba,
  input  logic              boton_abajo,
  input  logic              boton_izq,
  input  logic              boton_der,
  input  logic              boton_elige,
  input  logic              turno_p1,
  input  logic              turno_p2,
  input  logic              limpiar,
  output logic [2*N*N-1:0]  tablero,
  output logic [CW-1:0]     cuadro,
  output logic              p1_mm,
  output logic              p2_mm,
  output logic              jugada_invalida,
  output logic              tablero_lleno
);
  localparam int RW = clog2(N);
  localparam logic [RW-1:0] ULT = RW'(N-1);
  localparam logic [RW-1:0] MED = RW'(N/2);
  logic [4:0]        flanco;
  logic [RW-1:0]     fila_q, fila_d, col_q, col_d;
  logic [2*N*N-1:0]  tablero_q, tablero_d;
  logic [N*N-1:0]    ocupada;
  estado_t           estado_q, estado_d;
  logic              p1_q, p2_q, inv_q;
  logic              elige, mueve, arriba, abajo, izq, der, escribe, invalida;
  logic [1:0]        celda, marca;
  function automatic logic [RW-1:0] menos(input logic [RW-1:0] v);
    return (v == '0) ? ((WRAP != 0) ? ULT : '0) : v - RW'(1);
  endfunction
  function automatic logic [RW-1:0] mas(input logic [RW-1:0] v);
    return (v == ULT) ? ((WRAP != 0) ? '0 : ULT) : v + RW'(1);
  endfunction
  detector_flanco #(.W(5)) u_flanco (
    .clk      (clk),
    .reset    (reset),
    .nivel_i  ({boton_elige, boton_der, boton_izq, boton_abajo, boton_arriba}),
    .flanco_o (flanco)
  );
  assign cuadro = CW'(fila_q) * CW'(N) + CW'(col_q);
  // limpiar beats every edge, elige beats moves, moves resolve in fixed order
  always_comb begin
    elige    = !limpiar && flanco[B_ELIGE];
    mueve    = !limpiar && !flanco[B_ELIGE];
    arriba   = mueve && flanco[B_ARRIBA];
    abajo    = mueve && !flanco[B_ARRIBA] && flanco[B_ABAJO];
    izq      = mueve && !(|flanco[B_ABAJO:B_ARRIBA]) && flanco[B_IZQ];
    der      = mueve && !(|flanco[B_IZQ:B_ARRIBA]) && flanco[B_DER];
    fila_d   = arriba ? menos(fila_q) : abajo ? mas(fila_q) : fila_q;
    col_d    = izq ? menos(col_q) : der ? mas(col_q) : col_q;
    celda    = tablero_q[2*cuadro +: 2];
    marca    = turno_p1 ? CASILLA_EQUIS : CASILLA_CIRCULO;
    escribe  = elige && estado_q == ESPERA && (turno_p1 ^ turno_p2) && celda == CASILLA_VACIA;
    invalida = elige && (estado_q == LLENO || ((turno_p1 || turno_p2) && !escribe));
    estado_d = limpiar ? ESPERA : (escribe && &ocupada) ? LLENO : estado_q;
  end
  for (genvar k = 0; k < N*N; k++) begin : g_celda
    assign tablero_d[2*k +: 2] = limpiar ? CASILLA_VACIA :
                                 (escribe && cuadro == CW'(k)) ? marca : tablero_q[2*k +: 2];
    assign ocupada[k] = |tablero_d[2*k +: 2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fila_q    <= MED;
      col_q     <= MED;
      tablero_q <= '0;
      estado_q  <= ESPERA;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      fila_q    <= fila_d;
      col_q     <= col_d;
      tablero_q <= tablero_d;
      estado_q  <= estado_d;
      p1_q      <= escribe && turno_p1;
      p2_q      <= escribe && turno_p2;
      inv_q     <= invalida;
    end
  end
  assign tablero         = tablero_q;
  assign p1_mm           = p1_q;
  assign p2_mm           = p2_q;
  assign jugada_invalida = inv_q;
  assign tablero_lleno   = estado_q == LLENO;
endmodule

// File: tb/tb_selector_tablero.sv
// tb_selector_tablero: directed checks on N=3 wrap, N=3 saturate and N=4 wrap selectors sharing inputs
module tb_selector_tablero;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic limpiar = 1'b0;
  logic turno_p1 = 1'b0;
  logic turno_p2 = 1'b0;
  logic [4:0] btn = 5'b0;
  logic [17:0] ta, tbb;
  logic [31:0] tc;
  logic [3:0] ca, cb, cc;
  logic p1a, p2a, inva, llena, p1b, p2b, invb, llenb, p1c, p2c, invc, llenc;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  selector_tablero #(.N(3), .WRAP(1)) dut_a (
    .clk(clk), .reset(reset), .boton_arriba(btn[0]), .boton_abajo(btn[1]), .boton_izq(btn[2]),
    .boton_der(btn[3]), .boton_elige(btn[4]), .turno_p1(turno_p1), .turno_p2(turno_p2),
    .limpiar(limpiar), .tablero(ta), .cuadro(ca), .p1_mm(p1a), .p2_mm(p2a),
    .jugada_invalida(inva), .tablero_lleno(llena));
  selector_tablero #(.N(3), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .boton_arriba(btn[0]), .boton_abajo(btn[1]), .boton_izq(btn[2]),
    .boton_der(btn[3]), .boton_elige(btn[4]), .turno_p1(turno_p1), .turno_p2(turno_p2),
    .limpiar(limpiar), .tablero(tbb), .cuadro(cb), .p1_mm(p1b), .p2_mm(p2b),
    .jugada_invalida(invb), .tablero_lleno(llenb));
  selector_tablero #(.N(4), .WRAP(1)) dut_c (
    .clk(clk), .reset(reset), .boton_arriba(btn[0]), .boton_abajo(btn[1]), .boton_izq(btn[2]),
    .boton_der(btn[3]), .boton_elige(btn[4]), .turno_p1(turno_p1), .turno_p2(turno_p2),
    .limpiar(limpiar), .tablero(tc), .cuadro(cc), .p1_mm(p1c), .p2_mm(p2c),
    .jugada_invalida(invc), .tablero_lleno(llenc));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic press(input logic [4:0] m);
    @(negedge clk) btn = m;
    @(negedge clk) btn = 5'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn = 5'b0;
    limpiar = 1'b0;
    turno_p1 = 1'b0;
    turno_p2 = 1'b0;
    @(negedge clk) reset = 1'b0;
  endtask
  task automatic fill(input int n);
    logic [63:0] exp;
    exp = '0;
    for (int k = 0; k < n*n; k++) begin
      turno_p1 = (k % 2 == 0);
      turno_p2 = !turno_p1;
      press(5'b10000);
      exp[2*k +: 2] = turno_p1 ? 2'b01 : 2'b10;
      chk($sformatf("fill%0d_p1_k%0d", n, k), n == 3 ? p1a : p1c, k % 2 == 0);
      chk($sformatf("fill%0d_lleno_k%0d", n, k), n == 3 ? llena : llenc, k == n*n-1);
      press(5'b01000);
      if (k % n == n-1) press(5'b00010);
    end
    chk($sformatf("fill%0d_tablero", n), n == 3 ? 64'(ta) : 64'(tc), exp);
  endtask
  initial begin
    btn = 5'b00001;
    repeat (2) @(negedge clk);
    chk("rst_tablero", 64'(ta), 0);
    chk("rst_cuadro", 64'(ca), 4);
    chk("rst_pulses", {p1a, p2a, inva}, 0);
    chk("rst_lleno", 64'(llena), 0);
    chk("rst_cuadro_n4", 64'(cc), 10);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_arriba", 64'(ca), 4);
    btn = 5'b0;
    press(5'b00001);
    chk("wrap_up1", 64'(ca), 1);
    chk("sat_up1", 64'(cb), 1);
    press(5'b00001);
    chk("wrap_up2", 64'(ca), 7);
    chk("sat_up2", 64'(cb), 1);
    press(5'b00001);
    press(5'b00100);
    chk("izq_to3", 64'(ca), 3);
    press(5'b00100);
    chk("izq_wrap", 64'(ca), 5);
    do_reset();
    turno_p1 = 1'b1;
    press(5'b10000);
    chk("p1_cell4", 64'(ta[9:8]), 2'b01);
    chk("p1_pulse", {p1a, p2a, inva}, 3'b100);
    @(negedge clk);
    chk("p1_pulse_end", 64'(p1a), 0);
    turno_p1 = 1'b0;
    turno_p2 = 1'b1;
    press(5'b10000);
    chk("occ_invalid", {p1a, p2a, inva}, 3'b001);
    chk("occ_cell_kept", 64'(ta[9:8]), 2'b01);
    press(5'b01001);
    chk("arriba_beats_der", 64'(ca), 1);
    press(5'b10010);
    chk("elige_beats_abajo", 64'(ca), 1);
    chk("p2_cell1", 64'(ta[3:2]), 2'b10);
    chk("p2_pulse", {p1a, p2a, inva}, 3'b010);
    do_reset();
    press(5'b00001);
    press(5'b00100);
    chk("goto0", 64'(ca), 0);
    fill(3);
    press(5'b10000);
    chk("lleno_invalid", {p1a, p2a, inva}, 3'b001);
    @(negedge clk) limpiar = 1'b1;
    @(negedge clk) limpiar = 1'b0;
    chk("clr_tablero", 64'(ta), 0);
    chk("clr_lleno", 64'(llena), 0);
    chk("clr_cuadro", 64'(ca), 0);
    press(5'b10000);
    chk("after_clr_write", 64'(ta), 1);
    do_reset();
    chk("n4_rst_cuadro", 64'(cc), 10);
    press(5'b01000);
    chk("n4_der1", 64'(cc), 11);
    press(5'b01000);
    chk("n4_der_wrap", 64'(cc), 8);
    press(5'b00001);
    press(5'b00001);
    chk("n4_goto0", 64'(cc), 0);
    fill(4);
    do_reset();
    chk("n4_midreset_tablero", 64'(tc), 0);
    chk("n4_midreset_lleno", 64'(llenc), 0);
    chk("n4_midreset_cuadro", 64'(cc), 10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
